// File: rtl/oscill_pkg.sv
// Shared oscilloscope definitions: datapath widths, measurement FSM states,
// system colour constants and the Vpp scaling helper.
package oscill_pkg;

  localparam int ADC_W  = 8;
  localparam int VFF_W  = 12;
  localparam int FREQ_W = 20;

  typedef logic [0:0] meas_state_t;
  localparam meas_state_t GATE   = 1'b0;
  localparam meas_state_t UPDATE = 1'b1;

  // RGB565 colours used by the display path
  localparam logic [15:0] COLOR_BLACK  = 16'h0000;
  localparam logic [15:0] COLOR_WHITE  = 16'hFFFF;
  localparam logic [15:0] COLOR_YELLOW = 16'hFFE0;
  localparam logic [15:0] COLOR_GREEN  = 16'h07E0;

  // Peak-to-peak code span to millivolts, truncating and saturating to 12 bits
  function automatic logic [VFF_W-1:0] vpp_mv(input logic [ADC_W-1:0] amp,
                                              input logic [12:0] vfs);
    logic [20:0] prod;
    logic [12:0] shifted;
    prod    = 21'(amp) * 21'(vfs);
    shifted = prod[20:8];
    if (shifted > 13'd4095) begin
      vpp_mv = 12'd4095;
    end else begin
      vpp_mv = shifted[11:0];
    end
  endfunction

endpackage

// File: rtl/meas_xing_det.sv
// Hysteresis rising-crossing detector with a saturating crossing counter.
// The LOW/HIGH state survives clear so crossings are not double-counted at gate edges.
module meas_xing_det
  import oscill_pkg::*;
#(
  parameter int HYST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADC_W-1:0]  sample,
  input  logic [ADC_W-1:0]  thr,
  input  logic              clear,
  input  logic              en,
  output logic [FREQ_W-1:0] count
);

  logic              high_r;
  logic [FREQ_W-1:0] count_r;
  logic [8:0]        hi_sum_s;
  logic [8:0]        lo_diff_s;
  logic [ADC_W-1:0]  hi_lvl_s;
  logic [ADC_W-1:0]  lo_lvl_s;

  // Band edges clamp to the code range; a borrow in the 9-bit difference means below zero
  assign hi_sum_s  = {1'b0, thr} + 9'(HYST);
  assign lo_diff_s = {1'b0, thr} - 9'(HYST);
  assign hi_lvl_s  = hi_sum_s[8]  ? 8'd255 : hi_sum_s[7:0];
  assign lo_lvl_s  = lo_diff_s[8] ? 8'd0   : lo_diff_s[7:0];

  // Crossing state machine and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_r  <= 1'b0;
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (en) begin
      if (!high_r && (sample >= hi_lvl_s)) begin
        high_r <= 1'b1;
        if (count_r != {FREQ_W{1'b1}}) begin
          count_r <= count_r + FREQ_W'(1);
        end
      end else if (high_r && (sample <= lo_lvl_s)) begin
        high_r <= 1'b0;
      end
    end
  end

  assign count = count_r;

endmodule

// File: rtl/meas_vff_freq.sv
// Gated Vpp / frequency measurement on the ADC stream (clk_32M domain).
// Optional MEAS_AVG_EN: data_vff becomes the mean of the last four gate results.
module meas_vff_freq
  import oscill_pkg::*;
#(
  parameter int GATE_CYCLES = 32000000,
  parameter int VFS_MV      = 3300,
  parameter int HYST        = 8,
  parameter int MIN_AMP     = 16
) (
  input  logic              clk_meas,
  input  logic              rst_n_meas,
  input  logic [ADC_W-1:0]  ad_data,
  output logic [VFF_W-1:0]  data_vff,
  output logic [FREQ_W-1:0] data_freq,
  output logic              data_valid
);

  localparam int CNT_W = $clog2(GATE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GATE_CYCLES - 1);

  meas_state_t       state_r;
  logic [CNT_W-1:0]  gate_cnt_r;
  logic [ADC_W-1:0]  cur_max_r;
  logic [ADC_W-1:0]  cur_min_r;
  logic [ADC_W-1:0]  thr_r;
  logic [ADC_W-1:0]  amp_s;
  logic [8:0]        mid_sum_s;
  logic [VFF_W-1:0]  vpp_s;
  logic [VFF_W-1:0]  vff_s;
  logic [FREQ_W-1:0] count_s;
  logic [FREQ_W-1:0] freq_s;

  meas_xing_det #(.HYST(HYST)) u_xing (
    .clk    (clk_meas),
    .rst_n  (rst_n_meas),
    .sample (ad_data),
    .thr    (thr_r),
    .clear  (state_r == UPDATE),
    .en     (state_r == GATE),
    .count  (count_s)
  );

  assign amp_s     = cur_max_r - cur_min_r;
  assign mid_sum_s = {1'b0, cur_max_r} + {1'b0, cur_min_r};
  assign vpp_s     = vpp_mv(amp_s, 13'(VFS_MV));
  assign freq_s    = (amp_s < 8'(MIN_AMP)) ? '0 : count_s;

`ifdef MEAS_AVG_EN
  logic [VFF_W-1:0] hist_r [3];
  logic [13:0]      sum_s;

  assign sum_s = 14'(vpp_s) + 14'(hist_r[0]) + 14'(hist_r[1]) + 14'(hist_r[2]);
  assign vff_s = sum_s[13:2];

  // Vpp history of the three previous gates
  always_ff @(posedge clk_meas or negedge rst_n_meas) begin
    if (!rst_n_meas) begin
      hist_r[0] <= '0;
      hist_r[1] <= '0;
      hist_r[2] <= '0;
    end else if (state_r == UPDATE) begin
      hist_r[0] <= vpp_s;
      hist_r[1] <= hist_r[0];
      hist_r[2] <= hist_r[1];
    end
  end
`else
  assign vff_s = vpp_s;
`endif

  // Gate sequencing, min/max tracking and result registers
  always_ff @(posedge clk_meas or negedge rst_n_meas) begin
    if (!rst_n_meas) begin
      state_r    <= GATE;
      gate_cnt_r <= '0;
      cur_max_r  <= 8'd0;
      cur_min_r  <= 8'd255;
      thr_r      <= 8'd128;
      data_vff   <= '0;
      data_freq  <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state_r)
        GATE: begin
          if (ad_data > cur_max_r) begin
            cur_max_r <= ad_data;
          end
          if (ad_data < cur_min_r) begin
            cur_min_r <= ad_data;
          end
          gate_cnt_r <= gate_cnt_r + CNT_W'(1);
          if (gate_cnt_r == LAST_CNT) begin
            state_r <= UPDATE;
          end
        end
        UPDATE: begin
          data_vff   <= vff_s;
          data_freq  <= freq_s;
          data_valid <= 1'b1;
          thr_r      <= mid_sum_s[8:1];
          cur_max_r  <= 8'd0;
          cur_min_r  <= 8'd255;
          gate_cnt_r <= '0;
          state_r    <= GATE;
        end
        default: begin
          state_r <= GATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meas_vff_freq.sv
// Scoreboard bench for meas_vff_freq with a 1000-cycle gate.
`timescale 1ns/1ps
module tb_meas_vff_freq;

  localparam int GATE = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ad_data = 8'd0;
  logic [11:0] data_vff;
  logic [19:0] data_freq;
  logic        data_valid;

  meas_vff_freq #(.GATE_CYCLES(GATE)) dut (
    .clk_meas   (clk),
    .rst_n_meas (rst_n),
    .ad_data    (ad_data),
    .data_vff   (data_vff),
    .data_freq  (data_freq),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int vff;
    int freq;
    int at;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hist[4];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Waveforms indexed by position within the gate: 0 square, 1 flat, 2 triangle, 3 sawtooth
  function automatic logic [7:0] wave(input int kind, input int n);
    int p;
    case (kind)
      0: wave = ((n % 100) < 50) ? 8'd50 : 8'd200;
      1: wave = 8'd90;
      2: begin
        p = n % 50;
        if (p < 25) wave = 8'(120 + (p * 15) / 24);
        else        wave = 8'(135 - ((p - 25) * 15) / 24);
      end
      default: wave = 8'(n % 256);
    endcase
  endfunction

  task automatic push_exp(input int raw_vff, input int freq, input int at);
    exp_t e;
`ifdef MEAS_AVG_EN
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = raw_vff;
    e.vff = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
`else
    e.vff = raw_vff;
`endif
    e.freq = freq;
    e.at   = at;
    sb_q.push_back(e);
  endtask

  // One full gate plus the discarded UPDATE sample; called #1 after a clock edge
  task automatic run_gate(input int kind, input int raw_vff, input int freq);
    push_exp(raw_vff, freq, cyc + GATE + 1);
    for (int n = 0; n <= GATE; n++) begin
      ad_data = wave(kind, n);
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every data_valid pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && data_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d, required none", cyc);
      end else begin
        e = sb_q.pop_front();
        check("data_vff", int'(data_vff), e.vff);
        check("data_freq", int'(data_freq), e.freq);
        check("pulse_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) hist[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vff", int'(data_vff), 0);
    check("reset_freq", int'(data_freq), 0);
    check("reset_valid", int'(data_valid), 0);
    rst_n = 1'b1;

    for (int g = 0; g < 3; g++) run_gate(0, 1933, 10);   // square 50/200
    for (int g = 0; g < 3; g++) run_gate(1, 0, 0);       // flat 90
    for (int g = 0; g < 2; g++) run_gate(2, 193, 0);     // small triangle, amp 15
    for (int g = 0; g < 2; g++) run_gate(3, 3287, 4);    // full-swing sawtooth

    // Reset halfway through a gate: partial gate must vanish without a pulse
    for (int n = 0; n < 500; n++) begin
      ad_data = wave(0, n);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
    #1;
    check("midreset_vff", int'(data_vff), 0);
    check("midreset_freq", int'(data_freq), 0);
    check("midreset_valid", int'(data_valid), 0);
    repeat (10) @(posedge clk);
    #1;
    check("held_reset_valid", int'(data_valid), 0);
    rst_n = 1'b1;

    for (int g = 0; g < 5; g++) run_gate(0, 1933, 10);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
